// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 serial LED driver: one 24-bit GRB pixel per handshake, back-to-back frames, latch gap.
module ws2812_driver #(
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int LATCH_CYC = 4000
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic [23:0] grb,
    input  logic        valid,
    output logic        ready,
    output logic        dout,
    output logic        busy
);

    localparam int MAX_CYC = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    bit_idx, bit_n;
    logic [23:0]   shreg, shreg_n;
    logic          ready_n, dout_n, busy_n;
    logic          hs;
    logic [CW-1:0] hi_cyc;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ready   <= 1'b1;
            dout    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            ready   <= ready_n;
            dout    <= dout_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        hs      = valid && ready;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_n = SEND;
                    shreg_n = grb;
                    bit_n   = '0;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                if (cnt == CW'(BIT_CYC - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == 5'd23) begin
                        bit_n = '0;
                        if (hs) begin
                            shreg_n = grb;
                        end else begin
                            state_n = LATCH;
                            shreg_n = '0;
                        end
                    end else begin
                        shreg_n = {shreg[22:0], 1'b0};
                        bit_n   = bit_idx + 5'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LATCH: begin
                if (cnt == CW'(LATCH_CYC - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so they come straight out of flops.
        hi_cyc  = shreg_n[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
        dout_n  = (state_n == SEND) && (cnt_n < hi_cyc);
        ready_n = (state_n == IDLE) ||
                  ((state_n == SEND) && (bit_n == 5'd23) && (cnt_n == CW'(BIT_CYC - 1)));
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: doc/ws2812_driver.md
WS2812_DRIVER -- requirements
Module: ws2812_driver

Interface
REQ-001 The block SHALL have a parameter T0H_CYC, default 20, giving the high time of a '0' bit in clkin cycles.
REQ-002 The block SHALL have a parameter T1H_CYC, default 40, giving the high time of a '1' bit in clkin cycles.
REQ-003 The block SHALL have a parameter BIT_CYC, default 63, giving the total bit period in clkin cycles.
REQ-004 The block SHALL have a parameter LATCH_CYC, default 4000, giving the low latch/reset gap after the last pixel in clkin cycles.
REQ-005 The block SHALL have a port clkin, input, 1 bit: the single clock, the PLL divided output (50 MHz nominal). All logic is on its rising edge.
REQ-006 The block SHALL have a port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have a port grb, input, 24 bits: pixel colour, G[23:16] R[15:8] B[7:0], sent MSB first.
REQ-008 The block SHALL have a port valid, input, 1 bit: grb holds a pixel to send.
REQ-009 The block SHALL have a port ready, output, 1 bit: the block accepts grb this cycle.
REQ-010 The block SHALL have a port dout, output, 1 bit: registered serial line to the LED chain.
REQ-011 The block SHALL have a port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement three states, IDLE, SEND and LATCH, with registered outputs only.
REQ-013 A handshake SHALL occur on a rising edge where valid=1 and ready=1; grb SHALL be sampled only at a handshake, and valid SHALL have no effect when ready=0.
REQ-014 ready SHALL be 1 in IDLE, 1 in SEND only on the final cycle of bit 23 (bit index 23, cnt=BIT_CYC-1), and 0 otherwise, including all of LATCH.
REQ-015 At a handshake in IDLE, the next state SHALL be SEND, the shift register SHALL load grb, bit index SHALL be 0 and cnt SHALL be 0; dout SHALL be 1 starting the cycle after the handshake (latency 1).
REQ-016 In SEND, dout SHALL be 1 while cnt < (current bit ? T1H_CYC : T0H_CYC), and 0 for the remainder of the bit.
REQ-017 cnt SHALL count 0..BIT_CYC-1 and wrap to 0; at the wrap the shift register SHALL shift left by one and bit index SHALL increment.
REQ-018 At the end of bit 23, if a handshake occurs the block SHALL start the new pixel with no gap (bit 0, cnt 0, dout=1 next cycle).
REQ-019 At the end of bit 23 with no handshake, the block SHALL enter LATCH with dout=0.
REQ-020 LATCH SHALL hold dout=0 for exactly LATCH_CYC cycles, then enter IDLE.
REQ-021 The total pixel duration SHALL be exactly 24*BIT_CYC cycles; the number of pixels per frame SHALL be unbounded, and a frame SHALL end only by valid being low at a pixel boundary.
REQ-022 Counter widths SHALL be sized with clog2 of the largest of BIT_CYC and LATCH_CYC; no counter SHALL overflow for legal parameters.
REQ-023 Legal parameters SHALL be 0 < T0H_CYC < T1H_CYC < BIT_CYC and LATCH_CYC >= 1; behaviour outside this range is undefined.
REQ-024 In IDLE, dout SHALL be 0 and grb SHALL be ignored unless valid=1.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL enter IDLE, with dout=0, busy=0, ready=1 from the next cycle, and cnt, bit index and shift register at 0.
REQ-026 A reset during SEND or LATCH SHALL discard the pixel in progress without completing it or its latch gap.
REQ-027 A handshake on the same edge as rst_n=0 SHALL be ignored.

Verification
REQ-028 The bench SHALL apply reset, then a single grb=24'hFFFFFF with valid held high for one cycle; the required response is 24 pulses, each high for 40 cycles and low for 23, followed by 4000 low cycles, then busy=0 and ready=1.
REQ-029 The bench SHALL send grb=24'h000000 once; the required response is 24 pulses, each high for 20 cycles and low for 43.
REQ-030 The bench SHALL send grb=24'hA50F3C and decode dout by its high width; the decoded bits SHALL equal A50F3C, MSB first.
REQ-031 The bench SHALL hold valid=1 with three pixels back-to-back; ready SHALL pulse on the last cycle of bit 23, there SHALL be no gap between pixels, the total SHALL be 3*24*63 cycles, and a single LATCH SHALL follow.
REQ-032 The bench SHALL assert valid during LATCH; ready SHALL stay 0, and the pixel SHALL be accepted on the first IDLE cycle, with dout=1 on the next cycle.
REQ-033 The bench SHALL assert rst_n=0 for one cycle during bit 10 of a pixel; dout=0 and busy=0 SHALL follow on the next cycle, no further pulses SHALL occur, and a subsequent pixel SHALL transmit correctly.
